// File: rtl/bpsk_demodulator.sv
// BPSK correlation receiver: multiplies each received sample by the local sine reference,
// integrates over one carrier period per bit and assembles LSB-first DATA_WIDTH-bit words.
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12,
  parameter int WEAK_THRESH   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic signed [SAMPLE_WIDTH-1:0]   signal_in,
  input  logic signed [SAMPLE_WIDTH-1:0]   ref_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic                             weak_out,
  output logic                             locked
);

  localparam int CNT_W  = $clog2(SAMPLE_NUMBER);
  localparam int PROD_W = 2 * SAMPLE_WIDTH;
  localparam int ACC_W  = PROD_W + CNT_W;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    r_state;
  logic signed [PROD_W-1:0]  r_prod_p1;
  logic [CNT_W-1:0]          r_cnt_p1;
  logic                      r_vld_p1;
  logic signed [ACC_W-1:0]   r_acc_p2;
  logic [BIT_W-1:0]          r_bitcnt_p2;
  logic [DATA_WIDTH-1:0]     r_word_p2;
  logic                      r_weak_p2;
  logic [DATA_WIDTH-1:0]     r_data_out;
  logic                      r_data_valid;
  logic                      r_weak_out;

  logic                      w_take;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_last;
  logic                      w_bit;
  logic                      w_weak_word;
  logic [DATA_WIDTH-1:0]     w_word;

  function automatic logic [ACC_W-1:0] f_abs(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
  endfunction

  // A zero correlation carries no information and decodes as 0.
  function automatic logic f_decide_bit(input logic signed [ACC_W-1:0] v);
    return (v > $signed(ACC_W'(0)));
  endfunction

  function automatic logic f_is_weak(input logic signed [ACC_W-1:0] v);
    return (f_abs(v) <= ACC_W'(WEAK_THRESH));
  endfunction

  assign w_take = en && ((r_state == S_RUN) || (cnt_in == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (en && (cnt_in == '0)) r_state <= S_RUN;
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: sample-by-reference product
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_prod_p1 <= signal_in * ref_in;
      r_cnt_p1  <= cnt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_vld_p1 <= 1'b0;
    else      r_vld_p1 <= w_take;
  end

  // Stage p2: integrate over the period and decide the bit at its last sample
  assign w_prod_ext = $signed({{CNT_W{r_prod_p1[PROD_W-1]}}, r_prod_p1});
  assign w_sum      = ((r_cnt_p1 == '0) ? $signed(ACC_W'(0)) : r_acc_p2) + w_prod_ext;
  assign w_last     = (r_cnt_p1 == CNT_W'(SAMPLE_NUMBER - 1));
  assign w_bit      = f_decide_bit(w_sum);
  assign w_weak_word = r_weak_p2 | f_is_weak(w_sum);

  always_comb begin
    w_word = r_word_p2;
    w_word[r_bitcnt_p2] = w_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc_p2     <= '0;
      r_bitcnt_p2  <= '0;
      r_word_p2    <= '0;
      r_weak_p2    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_weak_out   <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (r_vld_p1) begin
        r_acc_p2 <= w_sum;
        if (w_last) begin
          r_word_p2 <= w_word;
          if (r_bitcnt_p2 == BIT_W'(DATA_WIDTH - 1)) begin
            r_data_out   <= w_word;
            r_weak_out   <= w_weak_word;
            r_data_valid <= 1'b1;
            r_bitcnt_p2  <= '0;
            r_weak_p2    <= 1'b0;
          end else begin
            r_bitcnt_p2  <= r_bitcnt_p2 + 1'b1;
            r_weak_p2    <= w_weak_word;
          end
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign weak_out   = r_weak_out;
  assign locked     = (r_state == S_RUN);

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator: a sample-level correlation model predicts every output
// each cycle, and literal word/flag expectations pin the model per scenario.
module tb_bpsk_demodulator;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b0;
  logic signed [11:0] signal_in = '0;
  logic signed [11:0] ref_in = '0;
  logic [7:0]         cnt_in = '0;
  logic [11:0]        data_out;
  logic               data_valid;
  logic               weak_out;
  logic               locked;

  bpsk_demodulator #(
    .SAMPLE_NUMBER(256), .SAMPLE_WIDTH(12), .DATA_WIDTH(12), .WEAK_THRESH(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .signal_in(signal_in), .ref_in(ref_in),
    .cnt_in(cnt_in), .data_out(data_out), .data_valid(data_valid),
    .weak_out(weak_out), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  logic [11:0] last_word = '0;
  logic        last_weak = 1'b0;
  logic        chk_on = 1'b0;

  // Model state
  logic        m_locked = 1'b0;
  longint      m_acc = 0;
  int          m_bit = 0;
  logic [11:0] m_word = '0;
  logic        m_weak = 1'b0;
  logic        pend_v = 1'b0;
  logic [11:0] pend_w = '0;
  logic        pend_k = 1'b0;
  logic        exp_valid = 1'b0;
  logic [11:0] exp_data = '0;
  logic        exp_weak = 1'b0;
  logic        exp_locked = 1'b0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("data_valid", data_valid, exp_valid);
      chk("locked", locked, exp_locked);
      chk("data_out", data_out, exp_data);
      chk("weak_out", weak_out, exp_weak);
      if (data_valid) begin
        n_valid++;
        last_word = data_out;
        last_weak = weak_out;
      end
    end
  end

  function automatic logic signed [11:0] sine(input int n);
    real x;
    int  v;
    x = 2047.0 * $sin(2.0 * 3.14159265358979 * n / 256.0);
    v = $rtoi(x);
    return v[11:0];
  endfunction

  task automatic tick(input logic rv, input logic ev, input logic signed [11:0] s,
                      input logic signed [11:0] r, input int c);
    rst = rv; en = ev; signal_in = s; ref_in = r; cnt_in = c[7:0];
    @(posedge clk);
    if (!rv) begin
      m_locked = 0; m_acc = 0; m_bit = 0; m_word = '0; m_weak = 0;
      pend_v = 0; exp_valid = 0; exp_data = '0; exp_weak = 0;
    end else begin
      exp_valid = pend_v;
      if (pend_v) begin exp_data = pend_w; exp_weak = pend_k; end
      pend_v = 0;
      if (ev && (m_locked || c == 0)) begin
        m_locked = 1;
        if (c == 0) m_acc = 0;
        m_acc += longint'(s) * longint'(r);
        if (c == 255) begin
          m_word[m_bit] = (m_acc > 0);
          m_weak = m_weak | (m_acc == 0);
          if (m_bit == 11) begin
            pend_v = 1; pend_w = m_word; pend_k = m_weak;
            m_bit = 0; m_weak = 0;
          end else begin
            m_bit++;
          end
        end
      end
    end
    exp_locked = m_locked;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 12'sd0, 12'sd0, 0);
  endtask

  // Transmit one word; -1 disables the dead-bit, en-gap and reset-abort options.
  task automatic send_word(input logic [11:0] w, input int dead_bit, input int gap_a,
                           input int gap_b, input int rst_bit);
    logic signed [11:0] s_ref, s_sig;
    for (int b = 0; b < 12; b++) begin
      for (int n = 0; n < 256; n++) begin
        s_ref = sine(n);
        s_sig = w[b] ? s_ref : -s_ref;
        if (b == dead_bit) s_sig = 12'sd0;
        if ((b == gap_a || b == gap_b) && n == 50)
          for (int g = 0; g < 10; g++) tick(1'b1, 1'b0, s_sig, s_ref, n);
        if (b == rst_bit && n == 30) begin
          tick(1'b0, 1'b1, s_sig, s_ref, n);
          chk("rst_unlocked", locked, 0);
        end
        tick(1'b1, 1'b1, s_sig, s_ref, n);
        if (b == rst_bit && n == 255) chk("still_unlocked", locked, 0);
      end
      if (b == rst_bit) break;
    end
  endtask

  initial begin
    // 1 Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'($urandom), 12'($urandom), 12'($urandom), int'($urandom_range(0, 255)));
      chk_on = 1'b1;
    end
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_weak_out", weak_out, 0);
    chk("rst_locked", locked, 0);

    // 2 Loopback
    n_valid = 0;
    send_word(12'hA5C, -1, -1, -1, -1);
    idle(3);
    chk("loop_count", n_valid, 1);
    chk("loop_word", last_word, 12'hA5C);
    chk("loop_weak", last_weak, 0);

    // 3 Late start: back to IDLE, then en rises mid-period
    tick(1'b0, 1'b0, 12'sd0, 12'sd0, 0);
    n_valid = 0;
    for (int n = 100; n < 256; n++) begin
      tick(1'b1, 1'b1, sine(n), sine(n), n);
      if (n == 100 || n == 255) chk("late_unlocked", locked, 0);
    end
    tick(1'b1, 1'b1, -sine(0), sine(0), 0);
    chk("late_locked", locked, 1);
    for (int n = 1; n < 256; n++) tick(1'b1, 1'b1, -sine(n), sine(n), n);
    // first period above was bit 0 of 12'h3C1 sent as 0? correct it by resending whole word
    tick(1'b0, 1'b0, 12'sd0, 12'sd0, 0);
    for (int n = 200; n < 256; n++) tick(1'b1, 1'b1, sine(n), sine(n), n);
    send_word(12'h3C1, -1, -1, -1, -1);
    idle(3);
    chk("late_count", n_valid, 1);
    chk("late_word", last_word, 12'h3C1);

    // 4 en gaps in bits 3 and 7
    n_valid = 0;
    send_word(12'hA5C, -1, 3, 7, -1);
    idle(3);
    chk("gap_count", n_valid, 1);
    chk("gap_word", last_word, 12'hA5C);

    // 5 Dead symbol, then a clean word
    n_valid = 0;
    send_word(12'hFFF, 4, -1, -1, -1);
    idle(3);
    chk("dead_word", last_word, 12'hFEF);
    chk("dead_weak", last_weak, 1);
    send_word(12'h123, -1, -1, -1, -1);
    idle(3);
    chk("clean_word", last_word, 12'h123);
    chk("clean_weak", last_weak, 0);
    chk("dead_count", n_valid, 2);

    // 6 Reset mid-word
    n_valid = 0;
    send_word(12'h5A5, -1, -1, -1, 5);
    idle(3);
    chk("abort_count", n_valid, 0);
    send_word(12'h6B7, -1, -1, -1, -1);
    idle(3);
    chk("after_rst_count", n_valid, 1);
    chk("after_rst_word", last_word, 12'h6B7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
